// File: rtl/mem_responder.sv
// Word-addressed data-port responder: RAM, LED register, free-running cycle counter and,
// when MEM_RESPONDER_TIMER_EN is defined, a compare register with a sticky match flag.
module mem_responder #(
    parameter int RAM_WORDS = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        mem_write,
    output logic [31:0] read_data,
    output logic [7:0]  leds,
    output logic        timer_irq
);

    localparam int RAM_AW = $clog2(RAM_WORDS);

    // Register map, as word addresses (byte address >> 2).
    localparam logic [29:0] LED_WORD   = 30'h0000_4000;
    localparam logic [29:0] COUNT_WORD = 30'h0000_4001;
    localparam logic [29:0] CMP_WORD   = 30'h0000_4002;
    localparam logic [29:0] STAT_WORD  = 30'h0000_4003;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_LED,
        SEL_COUNT,
        SEL_CMP,
        SEL_STAT
    } sel_e;

    sel_e               sel;
    logic [29:0]        word_addr;
    logic [RAM_AW-1:0]  ram_index;
    logic               ram_hit;
    logic               wr_en;
    logic [31:0]        count;
    logic [31:0]        ram [RAM_WORDS];
    logic               unused_byte_offset;

    assign word_addr          = address[31:2];
    assign ram_index          = address[RAM_AW+1:2];
    assign ram_hit            = (address[31:RAM_AW+2] == '0);
    assign wr_en              = mem_write && !reset;
    assign unused_byte_offset = ^address[1:0];

    // Address decode: fully decoded, anything not listed reads as zero.
    always_comb begin
        // NOTE: assign every always_comb output a default first so no path leaves it unassigned (latch).
        sel = SEL_NONE;
        if (ram_hit) begin
            sel = SEL_RAM;
        end else begin
            case (word_addr)
                LED_WORD:   sel = SEL_LED;
                COUNT_WORD: sel = SEL_COUNT;
`ifdef MEM_RESPONDER_TIMER_EN
                CMP_WORD:   sel = SEL_CMP;
                STAT_WORD:  sel = SEL_STAT;
`endif
                default:    sel = SEL_NONE;
            endcase
        end
    end

    // RAM: combinational read returns the pre-write contents during a write cycle.
    // NOTE: the RAM array has no reset so it maps onto block RAM; contents are undefined until written.
    always_ff @(posedge clock) begin
        if (wr_en && sel == SEL_RAM) begin
            ram[ram_index] <= write_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            leds <= '0;
        end else if (wr_en && sel == SEL_LED) begin
            leds <= write_data[7:0];
        end
    end

    // Free-running counter; writes to its address are ignored, wrap is natural overflow.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count + 32'd1;
        end
    end

`ifdef MEM_RESPONDER_TIMER_EN
    logic [31:0] cmp;
    logic        flag;
    logic        match;
    logic        clear;

    // Compare against registered CMP so a CMP write cannot match in its own cycle.
    assign match = (count == cmp) && (cmp != '0);
    assign clear = wr_en && (sel == SEL_STAT) && write_data[0];

    always_ff @(posedge clock) begin
        if (reset) begin
            cmp  <= '0;
            flag <= 1'b0;
        end else begin
            if (wr_en && sel == SEL_CMP) begin
                cmp <= write_data;
            end
            if (match) begin
                flag <= 1'b1;
            end else if (clear) begin
                flag <= 1'b0;
            end
        end
    end

    assign timer_irq = flag;
`else
    assign timer_irq = 1'b0;
`endif

    always_comb begin
        read_data = '0;
        case (sel)
            SEL_RAM:   read_data = ram[ram_index];
            SEL_LED:   read_data = {24'b0, leds};
            SEL_COUNT: read_data = count;
`ifdef MEM_RESPONDER_TIMER_EN
            SEL_CMP:   read_data = cmp;
            SEL_STAT:  read_data = {31'b0, flag};
`endif
            default:   read_data = '0;
        endcase
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder; timer scenarios follow MEM_RESPONDER_TIMER_EN.
module tb_mem_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic        mem_write = 1'b0;
    logic [31:0] read_data;
    logic [7:0]  leds;
    logic        timer_irq;

    int checks = 0;
    int errors = 0;

    mem_responder #(.RAM_WORDS(1024)) dut (
        .clock      (clock),
        .reset      (reset),
        .address    (address),
        .write_data (write_data),
        .mem_write  (mem_write),
        .read_data  (read_data),
        .leds       (leds),
        .timer_irq  (timer_irq)
    );

    always #5 clock = ~clock;

    // Advance one full cycle; returns at the falling edge.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Drive the bus at the falling edge and let combinational outputs settle.
    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic we);
        address    = a;
        write_data = d;
        mem_write  = we;
        #1;
    endtask

    // Two reset edges; returns in the first cycle after the last reset edge with reset low.
    task automatic apply_reset();
        @(negedge clock);
        reset     = 1'b1;
        mem_write = 1'b0;
        step();
        step();
        reset = 1'b0;
        drive(32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (leds !== 8'h00) begin errors++; $display("FAIL reset_leds got=%h exp=%h", leds, 8'h00); end
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", timer_irq); end
        drive(32'h0001_0004, 32'h0, 1'b0);
        checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL reset_count got=%h exp=%h", read_data, 32'h0); end
        drive(32'h0001_0000, 32'h0, 1'b0);
        checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL reset_led_read got=%h exp=%h", read_data, 32'h0); end
`ifdef MEM_RESPONDER_TIMER_EN
        drive(32'h0001_0008, 32'h0, 1'b0);
        checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL reset_cmp got=%h exp=%h", read_data, 32'h0); end
        drive(32'h0001_000C, 32'h0, 1'b0);
        checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL reset_stat got=%h exp=%h", read_data, 32'h0); end
`endif
    endtask

    task automatic test_ram();
        drive(32'h0000_0010, 32'h1111_1111, 1'b1);
        step();
        drive(32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
        checks++; if (read_data !== 32'h1111_1111) begin errors++; $display("FAIL ram_old_in_write got=%h exp=%h", read_data, 32'h1111_1111); end
        step();
        drive(32'h0000_0010, 32'h0, 1'b0);
        checks++; if (read_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_read_10 got=%h exp=%h", read_data, 32'hDEAD_BEEF); end
        drive(32'h0000_0013, 32'h0, 1'b0);
        checks++; if (read_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_read_13 got=%h exp=%h", read_data, 32'hDEAD_BEEF); end
        // Byte offset ignored on write as well; top word of the RAM.
        drive(32'h0000_0FFE, 32'hCAFE_0FFC, 1'b1);
        step();
        drive(32'h0000_0000, 32'h55AA_1234, 1'b1);
        step();
        drive(32'h0000_0FFC, 32'h0, 1'b0);
        checks++; if (read_data !== 32'hCAFE_0FFC) begin errors++; $display("FAIL ram_top_word got=%h exp=%h", read_data, 32'hCAFE_0FFC); end
        drive(32'h0000_0010, 32'h0, 1'b0);
        checks++; if (read_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_keep_10 got=%h exp=%h", read_data, 32'hDEAD_BEEF); end
        // Just past the RAM: must not alias word 0.
        drive(32'h0000_1000, 32'h0000_0BAD, 1'b1);
        step();
        drive(32'h0000_1000, 32'h0, 1'b0);
        checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL ram_gap_read got=%h exp=%h", read_data, 32'h0); end
        drive(32'h0000_0000, 32'h0, 1'b0);
        checks++; if (read_data !== 32'h55AA_1234) begin errors++; $display("FAIL ram_word0_alias got=%h exp=%h", read_data, 32'h55AA_1234); end
    endtask

    task automatic test_leds();
        drive(32'h0001_0000, 32'h0000_01A5, 1'b1);
        checks++; if (leds !== 8'h00) begin errors++; $display("FAIL led_before_edge got=%h exp=%h", leds, 8'h00); end
        step();
        drive(32'h0001_0000, 32'h0, 1'b0);
        checks++; if (leds !== 8'hA5) begin errors++; $display("FAIL led_value got=%h exp=%h", leds, 8'hA5); end
        checks++; if (read_data !== 32'h0000_00A5) begin errors++; $display("FAIL led_read got=%h exp=%h", read_data, 32'h0000_00A5); end
        drive(32'h0001_0010, 32'h0000_00FF, 1'b1);
        step();
        drive(32'h0001_0000, 32'h0, 1'b0);
        checks++; if (leds !== 8'hA5) begin errors++; $display("FAIL led_unmapped_write got=%h exp=%h", leds, 8'hA5); end
    endtask

    // Writes during reset are ignored; RAM keeps contents and stays readable.
    task automatic test_reset_blocks_writes();
        drive(32'h0000_0020, 32'hA0A0_A0A0, 1'b1);
        step();
        reset = 1'b1;
        drive(32'h0000_0020, 32'hB0B0_B0B0, 1'b1);
        checks++; if (read_data !== 32'hA0A0_A0A0) begin errors++; $display("FAIL reset_comb_read got=%h exp=%h", read_data, 32'hA0A0_A0A0); end
        step();
        drive(32'h0001_0000, 32'h0000_00FF, 1'b1);
        step();
        reset = 1'b0;
        drive(32'h0000_0020, 32'h0, 1'b0);
        checks++; if (read_data !== 32'hA0A0_A0A0) begin errors++; $display("FAIL reset_ram_write got=%h exp=%h", read_data, 32'hA0A0_A0A0); end
        checks++; if (leds !== 8'h00) begin errors++; $display("FAIL reset_led_clear got=%h exp=%h", leds, 8'h00); end
    endtask

    task automatic test_count();
        apply_reset();
        repeat (4) step();
        drive(32'h0001_0004, 32'h0000_1234, 1'b1);
        checks++; if (read_data !== 32'h4) begin errors++; $display("FAIL count_fifth got=%h exp=%h", read_data, 32'h4); end
        step();
        drive(32'h0001_0004, 32'h0, 1'b0);
        checks++; if (read_data !== 32'h5) begin errors++; $display("FAIL count_write_ignored got=%h exp=%h", read_data, 32'h5); end
        force dut.count = 32'hFFFF_FFFE;
        #1;
        release dut.count;
        #1;
        checks++; if (read_data !== 32'hFFFF_FFFE) begin errors++; $display("FAIL count_forced got=%h exp=%h", read_data, 32'hFFFF_FFFE); end
        step();
        checks++; if (read_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL count_max got=%h exp=%h", read_data, 32'hFFFF_FFFF); end
        step();
        checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL count_wrap got=%h exp=%h", read_data, 32'h0); end
        step();
        checks++; if (read_data !== 32'h1) begin errors++; $display("FAIL count_after_wrap got=%h exp=%h", read_data, 32'h1); end
        // Reset mid-count: zero after the reset edge, first increment on the next edge.
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL count_mid_reset got=%h exp=%h", read_data, 32'h0); end
        step();
        checks++; if (read_data !== 32'h1) begin errors++; $display("FAIL count_first_inc got=%h exp=%h", read_data, 32'h1); end
    endtask

    task automatic test_unmapped();
        logic [31:0] addrs [5];
        addrs[0] = 32'h0000_F000;
        addrs[1] = 32'h0002_0000;
        addrs[2] = 32'hFFFF_FFFC;
        addrs[3] = 32'h0001_0010;
        addrs[4] = 32'h0011_0004;
        for (int i = 0; i < 5; i++) begin
            drive(addrs[i], 32'h0, 1'b0);
            checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL unmapped_%h got=%h exp=%h", addrs[i], read_data, 32'h0); end
        end
    endtask

`ifdef MEM_RESPONDER_TIMER_EN
    task automatic test_timer();
        apply_reset();
        // count=0, cmp=0: a zero compare must never set the flag.
        repeat (3) step();
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL timer_cmp_zero got=%b exp=0", timer_irq); end
        apply_reset();
        drive(32'h0001_0008, 32'd20, 1'b1);
        step();
        drive(32'h0001_0004, 32'h0, 1'b0);
        for (int i = 1; i < 20; i++) begin
            checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL timer_early_%0d got=%b exp=0", i, timer_irq); end
            step();
        end
        checks++; if (read_data !== 32'd20) begin errors++; $display("FAIL timer_count20 got=%h exp=%h", read_data, 32'd20); end
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL timer_at_match got=%b exp=0", timer_irq); end
        step();
        checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL timer_set got=%b exp=1", timer_irq); end
        drive(32'h0001_000C, 32'h0, 1'b0);
        checks++; if (read_data !== 32'h1) begin errors++; $display("FAIL timer_stat_read got=%h exp=%h", read_data, 32'h1); end
        drive(32'h0001_000C, 32'hFFFF_FFFE, 1'b1);
        step();
        checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL timer_clear_bit0_zero got=%b exp=1", timer_irq); end
        drive(32'h0001_000C, 32'h1, 1'b1);
        step();
        drive(32'h0001_000C, 32'h0, 1'b0);
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL timer_clear got=%b exp=0", timer_irq); end
        checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL timer_stat_clear got=%h exp=%h", read_data, 32'h0); end
    endtask

    task automatic test_timer_edges();
        apply_reset();
        repeat (5) step();
        // CMP written to the current count (5) must not match in the write cycle.
        drive(32'h0001_0008, 32'd5, 1'b1);
        step();
        drive(32'h0001_0008, 32'h0, 1'b0);
        checks++; if (read_data !== 32'd5) begin errors++; $display("FAIL cmp_readback got=%h exp=%h", read_data, 32'd5); end
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL cmp_same_cycle got=%b exp=0", timer_irq); end
        step();
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL cmp_same_cycle_late got=%b exp=0", timer_irq); end
        // count is 7 here; match at 10 coincides with a STAT clear, set wins.
        drive(32'h0001_0008, 32'd10, 1'b1);
        step();
        step();
        step();
        drive(32'h0001_0004, 32'h0, 1'b0);
        checks++; if (read_data !== 32'd10) begin errors++; $display("FAIL set_clear_count got=%h exp=%h", read_data, 32'd10); end
        drive(32'h0001_000C, 32'h1, 1'b1);
        step();
        drive(32'h0001_0004, 32'h0, 1'b0);
        checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL set_wins got=%b exp=1", timer_irq); end
    endtask
`else
    task automatic test_timer_absent();
        drive(32'h0001_0008, 32'hFFFF_FFFF, 1'b1);
        step();
        drive(32'h0001_000C, 32'hFFFF_FFFF, 1'b1);
        step();
        drive(32'h0001_0008, 32'h0, 1'b0);
        checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL no_timer_cmp got=%h exp=%h", read_data, 32'h0); end
        drive(32'h0001_000C, 32'h0, 1'b0);
        checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL no_timer_stat got=%h exp=%h", read_data, 32'h0); end
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL no_timer_irq got=%b exp=0", timer_irq); end
    endtask
`endif

    initial begin
        test_reset();
        test_ram();
        test_leds();
        test_reset_blocks_writes();
        test_count();
        test_unmapped();
`ifdef MEM_RESPONDER_TIMER_EN
        test_timer();
        test_timer_edges();
`else
        test_timer_absent();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
